// File: rtl/eth_feed_pkg.sv
// Shared types for the UDP payload feeder: FSM states, payload-source select and header sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Option ETH_FEED_SEQNUM_EN adds a 2-byte sequence-number header to each payload.
package eth_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Which source drives usr_data_o: buffer RAM or one of the sequence-number bytes.
  typedef enum logic [1:0] {
    SEL_RAM    = 2'd0,
    SEL_SEQ_HI = 2'd1,
    SEL_SEQ_LO = 2'd2
  } data_sel_t;

  localparam int SEQ_BYTES = 2;

`ifdef ETH_FEED_SEQNUM_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  localparam int HDR_BYTES = SEQ_EN ? SEQ_BYTES : 0;

  // UDP payload length as seen by the transmitter for a given buffered length.
  function automatic logic [15:0] frame_len(input logic [15:0] len);
    return len + 16'(HDR_BYTES);
  endfunction

endpackage

// File: rtl/eth_feed_ram.sv
// Simple dual-port DEPTH x 8 buffer RAM: synchronous write, registered read port (block-RAM friendly).
// Latency: read data valid 1 clock after re_i; write visible to reads from the following clock.
// Backpressure: none; the caller owns pointer and full/empty tracking.
module eth_feed_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port; the output register is cleared so usr_data_o resets to 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rdata_o <= '0;
    else if (re_i)  rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/eth_udp_payload_feeder.sv
// Buffers an ADC byte stream in a ring RAM and feeds it as UDP payload to the Ethernet transmitter.
// Latency: launch 1 clock after a full payload is buffered; next byte on usr_data_o 1 clock after usr_clken_i.
// Backpressure: none upstream (samples arriving while full are dropped, overflow_o set); ETH_FEED_SEQNUM_EN prepends a sequence number.
module eth_udp_payload_feeder
  import eth_feed_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int AW      = 11,
  parameter int GAP_CYC = 64
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  sample_i,
  input  logic        sample_valid_i,
  input  logic [15:0] cfg_len_i,
  input  logic        cfg_enable_i,
  input  logic        usr_clken_i,
  output logic        usr_start_o,
  output logic [7:0]  usr_data_o,
  output logic [15:0] usr_data_len_o,
  output logic [AW:0] fill_o,
  output logic        overflow_o,
  output logic        cfg_err_o,
  output logic        busy_o
);

  localparam logic [AW:0] FULL_LVL   = DEPTH[AW:0];
  localparam logic [15:0] MAX_LEN    = DEPTH[15:0];
  localparam int          GAP_LAST_I = GAP_CYC - 1;
  localparam logic [15:0] GAP_LAST   = GAP_LAST_I[15:0];

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] ram_raddr;
  logic [15:0]   len_q;
  logic [15:0]   byte_cnt;
  logic [15:0]   gap_cnt;
  logic [7:0]    ram_rdata;
  logic          wr_ok;
  logic          launch;
  logic          clken_send;
  logic          consume;
  logic          frame_done;
  logic          ram_re;

  assign cfg_err_o      = (cfg_len_i == 16'd0) || (cfg_len_i > MAX_LEN);
  assign wr_ok          = sample_valid_i && (fill_o < FULL_LVL);
  assign launch         = (state == ST_IDLE) && cfg_enable_i && !cfg_err_o &&
                          ({{(15-AW){1'b0}}, fill_o} >= cfg_len_i);
  assign clken_send     = (state == ST_SEND) && usr_clken_i;
  assign frame_done     = clken_send && ((byte_cnt + 16'd1) == len_q);
  assign busy_o         = (state != ST_IDLE);
  assign usr_data_len_o = len_q;
  // Read address runs one ahead of rd_ptr on a consuming strobe so the next byte is prefetched.
  assign ram_raddr      = rd_ptr + {{(AW-1){1'b0}}, consume};

`ifdef ETH_FEED_SEQNUM_EN
  logic [15:0] seq_q;
  data_sel_t   data_sel;

  // Header bytes come from the sequence counter; the buffer is only read once they are out.
  assign consume = clken_send && (data_sel == SEL_RAM);
  assign ram_re  = launch || consume || (clken_send && (data_sel == SEL_SEQ_LO));

  // Step through SEQ_HI, SEQ_LO, then buffer data; count frames as they complete.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      seq_q    <= '0;
      data_sel <= SEL_RAM;
    end else begin
      if (launch) begin
        data_sel <= SEL_SEQ_HI;
      end else if (clken_send) begin
        if (data_sel == SEL_SEQ_HI)      data_sel <= SEL_SEQ_LO;
        else if (data_sel == SEL_SEQ_LO) data_sel <= SEL_RAM;
      end
      if (frame_done) seq_q <= seq_q + 16'd1;
    end
  end

  assign usr_data_o = (data_sel == SEL_SEQ_HI) ? seq_q[15:8] :
                      (data_sel == SEL_SEQ_LO) ? seq_q[7:0]  : ram_rdata;
`else
  assign consume    = clken_send;
  assign ram_re     = launch || consume;
  assign usr_data_o = ram_rdata;
`endif

  eth_feed_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .we_i      (wr_ok),
    .waddr_i   (wr_ptr),
    .wdata_i   (sample_i),
    .re_i      (ram_re),
    .raddr_i   (ram_raddr),
    .rdata_o   (ram_rdata)
  );

  // Ring pointers, fill level and sticky overflow; simultaneous write and read leave fill as is.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_ok)   wr_ptr <= wr_ptr + 1'b1;
      if (consume) rd_ptr <= rd_ptr + 1'b1;
      if (sample_valid_i && !wr_ok) overflow_o <= 1'b1;
      case ({wr_ok, consume})
        2'b10:   fill_o <= fill_o + 1'b1;
        2'b01:   fill_o <= fill_o - 1'b1;
        default: fill_o <= fill_o;
      endcase
    end
  end

  // Frame sequencer: launch, wait for the start acknowledge, count payload bytes, then hold off.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ST_IDLE;
      usr_start_o <= 1'b0;
      len_q       <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            len_q       <= frame_len(cfg_len_i);
            byte_cnt    <= '0;
            usr_start_o <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          if (usr_clken_i) begin
            usr_start_o <= 1'b0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (usr_clken_i) begin
            byte_cnt <= byte_cnt + 16'd1;
            if (frame_done) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // Strobes during the gap belong to the transmitter's trailer; they only pause the count.
          if (!usr_clken_i) begin
            if (gap_cnt == GAP_LAST) state   <= ST_IDLE;
            else                     gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_udp_payload_feeder.sv
// Randomized bench for eth_udp_payload_feeder: acts as ADC writer and as the transmitter.
// Reference model: byte queue of buffered data, fill/overflow counters, expected launch timing.
// Handles builds with or without ETH_FEED_SEQNUM_EN.
module tb_eth_udp_payload_feeder;

  localparam int DEPTH   = 2048;
  localparam int GAP_CYC = 64;
`ifdef ETH_FEED_SEQNUM_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic        clk;
  logic        reset_n_i;
  logic [7:0]  sample_i;
  logic        sample_valid_i;
  logic [15:0] cfg_len_i;
  logic        cfg_enable_i;
  logic        usr_clken_i;
  logic        usr_start_o;
  logic [7:0]  usr_data_o;
  logic [15:0] usr_data_len_o;
  logic [11:0] fill_o;
  logic        overflow_o;
  logic        cfg_err_o;
  logic        busy_o;

  eth_udp_payload_feeder dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .cfg_len_i      (cfg_len_i),
    .cfg_enable_i   (cfg_enable_i),
    .usr_clken_i    (usr_clken_i),
    .usr_start_o    (usr_start_o),
    .usr_data_o     (usr_data_o),
    .usr_data_len_o (usr_data_len_o),
    .fill_o         (fill_o),
    .overflow_o     (overflow_o),
    .cfg_err_o      (cfg_err_o),
    .busy_o         (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errs   = 0;

  // Model and stimulus state.
  int         cyc = 0;
  logic       a_valid, a_clken, a_read;
  logic [7:0] a_data;
  int         mfill;
  bit         movf;
  logic [7:0] wq[$];
  logic [7:0] exp_q[$];
  logic [15:0] mseq;
  bit         tx_active;
  int         pulse_idx, div, clk_div, flen;
  int         frames_done, launches, last_end, ready_cyc;
  int         cur_len;
  bit         cur_en;
  int         wr_mode, wr_left;
  logic [7:0] wr_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit cfg_bad();
    return (cur_len == 0) || (cur_len > DEPTH);
  endfunction

  // Launch becomes legal once enabled, length valid and enough unassigned bytes are buffered.
  task automatic eval_ready();
    if (ready_cyc < 0 && cur_en && !cfg_bad() && wq.size() >= cur_len) ready_cyc = cyc;
  endtask

  task automatic set_cfg(input int len, input bit en);
    cur_len      = len;
    cur_en       = en;
    cfg_len_i    = len[15:0];
    cfg_enable_i = en;
    ready_cyc    = -1;
    if (!tx_active) eval_ready();
  endtask

  task automatic do_reset();
    reset_n_i      = 1'b0;
    sample_valid_i = 1'b0;
    usr_clken_i    = 1'b0;
    a_valid = 1'b0; a_clken = 1'b0; a_read = 1'b0; a_data = 8'h00;
    wq.delete(); exp_q.delete();
    mfill = 0; movf = 1'b0; mseq = 16'h0000;
    tx_active = 1'b0; pulse_idx = 0; div = 0;
    frames_done = 0; launches = 0; last_end = -1; ready_cyc = -1;
    wr_left = 0; wr_mode = 0;
    repeat (3) @(posedge clk);
    #1 reset_n_i = 1'b1;
  endtask

  // One clock: account for inputs taken at this edge, check, then act as transmitter and writer.
  task automatic step();
    int         exp_launch;
    logic [7:0] eb;
    bit         short_q;
    @(posedge clk);
    #1;
    cyc++;
    if (a_valid) begin
      if (mfill < DEPTH) begin
        wq.push_back(a_data);
        mfill++;
      end else begin
        movf = 1'b1;
      end
    end
    if (a_read) mfill--;
    check("fill", fill_o, mfill);
    check("overflow", overflow_o, movf);
    check("cfg_err", cfg_err_o, cfg_bad());
    if (!tx_active) eval_ready();
    a_clken = 1'b0;
    a_read  = 1'b0;

    if (!tx_active && usr_start_o) begin
      launches++;
      if (ready_cyc < 0)     exp_launch = 0;
      else if (last_end < 0) exp_launch = ready_cyc + 1;
      else                   exp_launch = (ready_cyc + 1 > last_end + GAP_CYC + 2) ?
                                          ready_cyc + 1 : last_end + GAP_CYC + 2;
      check("launch_cycle", cyc, exp_launch);
      check("data_len", usr_data_len_o, cur_len + HDR);
      check("busy_launch", busy_o, 1);
      exp_q.delete();
      if (HDR == 2) begin
        exp_q.push_back(mseq[15:8]);
        exp_q.push_back(mseq[7:0]);
      end
      mseq++;
      short_q = (wq.size() < cur_len);
      check("launch_fill", short_q, 0);
      for (int i = 0; i < cur_len && wq.size() > 0; i++) exp_q.push_back(wq.pop_front());
      tx_active = 1'b1;
      pulse_idx = 0;
      div       = 0;
      flen      = cur_len + HDR;
      ready_cyc = -1;
    end

    if (tx_active) begin
      if (div == 0) begin
        if (pulse_idx > 0) begin
          eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
          check($sformatf("byte%0d", pulse_idx - 1), usr_data_o, eb);
          check("start_drop", usr_start_o, 0);
          check("busy_send", busy_o, 1);
          if (pulse_idx > HDR) a_read = 1'b1;
        end
        a_clken = 1'b1;
        pulse_idx++;
        div = clk_div - 1;
        if (pulse_idx == flen + 1) begin
          tx_active = 1'b0;
          frames_done++;
          last_end = cyc;
        end
      end else begin
        div--;
      end
    end

    a_valid = 1'b0;
    if (wr_left > 0 && (wr_mode == 1 || $urandom_range(0, 1) == 0)) begin
      a_valid = 1'b1;
      a_data  = (wr_mode == 1) ? wr_val : 8'($urandom);
      wr_val++;
      wr_left--;
    end
    usr_clken_i    = a_clken;
    sample_valid_i = a_valid;
    sample_i       = a_data;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      step();
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  task automatic start_writes(input int mode, input int count);
    wr_mode = mode;
    wr_left = count;
    wr_val  = 8'h00;
  endtask

  initial begin
    int n;
    sample_i = 8'h00; sample_valid_i = 1'b0; usr_clken_i = 1'b0;
    cfg_len_i = 16'd16; cfg_enable_i = 1'b0; cur_len = 16; cur_en = 1'b0;
    clk_div = 2;
    do_reset();

    // Reset state.
    check("rst_start", usr_start_o, 0);
    check("rst_data", usr_data_o, 0);
    check("rst_len", usr_data_len_o, 0);
    check("rst_fill", fill_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_busy", busy_o, 0);

    // 16-byte frame of 0x00..0x0F, strobe every 8 clocks.
    set_cfg(16, 1'b1);
    clk_div = 8;
    start_writes(1, 16);
    run_frames(1, 2000);
    run_cycles(GAP_CYC + 16);
    check("t1_launches", launches, 1);
    check("t1_fill", fill_o, 0);
    check("t1_idle", busy_o, 0);

    // Overfill while disabled, then read the whole buffer back.
    do_reset();
    set_cfg(DEPTH, 1'b0);
    start_writes(1, DEPTH + 3);
    run_cycles(DEPTH + 10);
    check("t2_full", fill_o, DEPTH);
    check("t2_ovf", overflow_o, 1);
    clk_div = 2;
    set_cfg(DEPTH, 1'b1);
    run_frames(1, 6000);
    run_cycles(GAP_CYC + 16);
    check("t2_empty", fill_o, 0);
    check("t2_ovf_sticky", overflow_o, 1);

    // Invalid lengths never launch; a legal length equal to the fill does.
    do_reset();
    set_cfg(0, 1'b1);
    start_writes(2, 100);
    run_cycles(300);
    check("t3_err0", cfg_err_o, 1);
    set_cfg(4096, 1'b1);
    run_cycles(50);
    check("t3_err4096", cfg_err_o, 1);
    set_cfg(DEPTH + 1, 1'b1);
    run_cycles(20);
    check("t3_no_launch", launches, 0);
    set_cfg(DEPTH, 1'b1);
    run_cycles(4);
    check("t3_err_depth", cfg_err_o, 0);
    check("t3_wait", launches, 0);
    clk_div = 3;
    set_cfg(100, 1'b1);
    run_frames(1, 3000);

    // Three 1000-byte frames while streaming 3000 bytes through the pointer wrap.
    do_reset();
    set_cfg(1000, 1'b1);
    clk_div = 2;
    start_writes(1, 3000);
    run_frames(3, 20000);
    run_cycles(GAP_CYC + 16);
    check("t4_no_ovf", overflow_o, 0);
    check("t4_empty", fill_o, 0);

    // Reset during byte 5, then a clean frame after refilling.
    do_reset();
    set_cfg(16, 1'b1);
    clk_div = 4;
    start_writes(1, 16);
    n = 0;
    while (!(tx_active && pulse_idx == 6) && n < 2000) begin
      step();
      n++;
    end
    check("t5_reach", (tx_active && pulse_idx == 6), 1);
    reset_n_i = 1'b0;
    #1;
    check("t5_start", usr_start_o, 0);
    check("t5_data", usr_data_o, 0);
    check("t5_len", usr_data_len_o, 0);
    check("t5_fill", fill_o, 0);
    check("t5_ovf", overflow_o, 0);
    check("t5_busy", busy_o, 0);
    do_reset();
    set_cfg(16, 1'b1);
    start_writes(2, 16);
    run_frames(1, 3000);

    // Two short frames (carry the sequence number when that option is built in).
    do_reset();
    set_cfg(4, 1'b1);
    clk_div = 3;
    start_writes(2, 8);
    run_frames(2, 3000);

    // Random lengths, strobe rates and write densities.
    for (int r = 0; r < 4; r++) begin
      set_cfg($urandom_range(1, 300), 1'b1);
      clk_div = $urandom_range(2, 6);
      start_writes(2, 2 * cur_len);
      run_frames(frames_done + 2, 20000);
    end
    check("rand_no_ovf", overflow_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
